// File: rtl/divider_pkg.sv
// Shared constants for the signed restoring divider: operand widths, step numbers
// of the fixed-length operation sequence and the error quotient.
package divider_pkg;

    localparam int DVD_W = 16;
    localparam int DVS_W = 8;

    localparam logic [3:0] ST_LOAD      = 4'd0;
    localparam logic [3:0] ST_ITER_LAST = 4'd8;
    localparam logic [3:0] ST_FIX       = 4'd9;
    localparam logic [3:0] ST_DONE      = 4'd10;
    localparam logic [3:0] ST_CLEAR     = 4'd11;

    localparam logic [DVS_W-1:0] Q_ERR = 8'h80;

    // Two's-complement negate when neg is set; shared by the quotient and remainder fix-up.
    function automatic logic [DVS_W-1:0] apply_sign(input logic neg, input logic [DVS_W-1:0] mag);
        return neg ? (~mag + 1'b1) : mag;
    endfunction

endpackage

// File: rtl/restoring_div_step.sv
// One radix-2 restoring division step: shift the next dividend bit into the partial
// remainder, subtract the divisor magnitude if it fits, and report the quotient bit.
module restoring_div_step
    import divider_pkg::*;
(
    input  logic [DVS_W:0]   r_i,
    input  logic             q_msb_i,
    input  logic [DVS_W-1:0] uv_i,
    output logic [DVS_W:0]   r_o,
    output logic             q_bit_o
);

    logic [DVS_W:0] shifted;
    logic [DVS_W:0] divisor_ext;
    logic           unused_r_msb;

    // The partial remainder's top bit is dropped by the shift; it only matters in
    // overflow cases, whose results are replaced by the error pattern anyway.
    assign unused_r_msb = r_i[DVS_W];

    assign shifted     = {r_i[DVS_W-1:0], q_msb_i};
    assign divisor_ext = {1'b0, uv_i};
    assign q_bit_o     = (shifted >= divisor_ext);
    assign r_o         = q_bit_o ? (shifted - divisor_ext) : shifted;

endmodule

// File: rtl/signed_restoring_divider_module.sv
// Sequential signed 16/8 divider: magnitudes go through an 8-step unsigned restoring
// divider, then signs, overflow and divide-by-zero are applied; 12 cycles per operation.
module signed_restoring_divider_module
    import divider_pkg::*;
(
    input  logic             CLK,
    input  logic             RST,
    input  logic             Start_Sig,
    input  logic [DVD_W-1:0] Dividend,
    input  logic [DVS_W-1:0] Divisor,
    output logic             Done_Sig,
    output logic [DVS_W-1:0] Quotient,
    output logic [DVS_W-1:0] Remainder,
    output logic             Overflow,
    output logic             Div_Zero
);

    logic [3:0]       step_q, step_d;
    logic             sq_q, sq_d;
    logic             sr_q, sr_d;
    logic             dz_q, dz_d;
    logic             ov0_q, ov0_d;
    logic [DVS_W-1:0] uv_q, uv_d;
    logic [DVS_W:0]   r_q, r_d;
    logic [DVS_W-1:0] q_q, q_d;
    logic             done_q, done_d;
    logic [DVS_W-1:0] quot_q, quot_d;
    logic [DVS_W-1:0] rem_q, rem_d;
    logic             ovf_q, ovf_d;
    logic             divz_q, divz_d;

    logic [DVD_W-1:0] ud;
    logic [DVS_W-1:0] uv;
    logic [DVS_W:0]   step_r;
    logic             step_bit;
    logic             ovf_now;

    // 16'h8000 negates to itself, which read as unsigned is the required 32768.
    assign ud = Dividend[DVD_W-1] ? (~Dividend + 1'b1) : Dividend;
    assign uv = Divisor[DVS_W-1] ? (~Divisor + 1'b1) : Divisor;

    restoring_div_step u_step (
        .r_i     (r_q),
        .q_msb_i (q_q[DVS_W-1]),
        .uv_i    (uv_q),
        .r_o     (step_r),
        .q_bit_o (step_bit)
    );

    // Negative quotients may reach -128, positive ones only +127.
    assign ovf_now = !dz_q && (ov0_q || (!sq_q && (q_q > 8'd127)) || (sq_q && (q_q > 8'd128)));

    always_comb begin
        step_d = step_q;
        sq_d   = sq_q;
        sr_d   = sr_q;
        dz_d   = dz_q;
        ov0_d  = ov0_q;
        uv_d   = uv_q;
        r_d    = r_q;
        q_d    = q_q;
        done_d = done_q;
        quot_d = quot_q;
        rem_d  = rem_q;
        ovf_d  = ovf_q;
        divz_d = divz_q;

        if (Start_Sig) begin
            case (step_q)
                ST_LOAD: begin
                    sq_d   = Dividend[DVD_W-1] ^ Divisor[DVS_W-1];
                    sr_d   = Dividend[DVD_W-1];
                    uv_d   = uv;
                    dz_d   = (Divisor == '0);
                    ov0_d  = (ud[DVD_W-1:DVS_W] >= uv);
                    r_d    = {1'b0, ud[DVD_W-1:DVS_W]};
                    q_d    = ud[DVS_W-1:0];
                    step_d = step_q + 4'd1;
                end
                ST_FIX: begin
                    ovf_d  = ovf_now;
                    divz_d = dz_q;
                    if (dz_q || ovf_now) begin
                        quot_d = Q_ERR;
                        rem_d  = '0;
                    end else begin
                        quot_d = apply_sign(sq_q, q_q);
                        rem_d  = apply_sign(sr_q, r_q[DVS_W-1:0]);
                    end
                    step_d = ST_DONE;
                end
                ST_DONE: begin
                    done_d = 1'b1;
                    step_d = ST_CLEAR;
                end
                ST_CLEAR: begin
                    done_d = 1'b0;
                    step_d = ST_LOAD;
                end
                default: begin
                    if (step_q <= ST_ITER_LAST) begin
                        r_d    = step_r;
                        q_d    = {q_q[DVS_W-2:0], step_bit};
                        step_d = step_q + 4'd1;
                    end else begin
                        step_d = ST_LOAD;
                    end
                end
            endcase
        end
    end

    // NOTE: state is updated only with non-blocking assignments so every register
    // samples the pre-edge values computed above, regardless of statement order.
    always_ff @(posedge CLK) begin
        if (RST) begin
            step_q <= ST_LOAD;
            sq_q   <= 1'b0;
            sr_q   <= 1'b0;
            dz_q   <= 1'b0;
            ov0_q  <= 1'b0;
            uv_q   <= '0;
            r_q    <= '0;
            q_q    <= '0;
            done_q <= 1'b0;
            quot_q <= '0;
            rem_q  <= '0;
            ovf_q  <= 1'b0;
            divz_q <= 1'b0;
        end else begin
            step_q <= step_d;
            sq_q   <= sq_d;
            sr_q   <= sr_d;
            dz_q   <= dz_d;
            ov0_q  <= ov0_d;
            uv_q   <= uv_d;
            r_q    <= r_d;
            q_q    <= q_d;
            done_q <= done_d;
            quot_q <= quot_d;
            rem_q  <= rem_d;
            ovf_q  <= ovf_d;
            divz_q <= divz_d;
        end
    end

    assign Done_Sig  = done_q;
    assign Quotient  = quot_q;
    assign Remainder = rem_q;
    assign Overflow  = ovf_q;
    assign Div_Zero  = divz_q;

endmodule
